layer_scheduler: RTL and testbench
==================================

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 Parameter NUM_NEURONS, default 7: neurons in the layer, all time-multiplexed onto one shared neuron datapath, range 1..64.
REQ-002 Parameter PIPE_LAT, default 6: fixed cycles from neuron x/w/bias input to valid y output, range 1..16.
REQ-003 Parameter AW, default 8: weight-memory address width.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 start  in  1  one-cycle request to evaluate the layer.
REQ-007 layer_base  in  AW  weight-memory address of neuron 0 of this layer.
REQ-008 x_in  in  119  7 concatenated signed s17f layer inputs.
REQ-009 w_addr  out  AW  weight-memory read address.
REQ-010 w_rd  out  1  weight-memory read strobe; read data returns exactly 1 cycle later.
REQ-011 w_data  in  136  memory word {weights[135:17] (7x17), bias[16:0]}.
REQ-012 n_x, n_w, n_bias  out  119/119/17  drive the shared neuron datapath.
REQ-013 n_y  in  17  shared neuron output.
REQ-014 y_vec  out  17*NUM_NEURONS  layer results, neuron i at bits [17*i+16:17*i].
REQ-015 busy  out  1  high from the cycle after an accepted start until done.
REQ-016 done  out  1  one-cycle pulse when y_vec holds the complete new layer result.

Function
REQ-017 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-018 IDLE: start=1 latches x_in and layer_base, clears the issue counter, and moves to ISSUE.
REQ-019 ISSUE: one read per cycle, w_rd=1, w_addr=layer_base+k, for k=0..NUM_NEURONS-1; move to DRAIN after k=NUM_NEURONS-1.
REQ-020 n_w/n_bias SHALL equal w_data fields registered 0 cycles, i.e. driven combinationally in the cycle data returns; n_x SHALL equal the latched x for the whole job.
REQ-021 An issue tag pipeline (valid + index, depth 1+PIPE_LAT) tracks each read; when a tag emerges, n_y is written into slot index of y_vec.
REQ-022 Timing: with start sampled at cycle 0, neuron k's result is captured at cycle k+2+PIPE_LAT.
REQ-023 DRAIN: move to DONE once the tag pipeline is empty. DONE: assert done for one cycle, then return to IDLE; done therefore falls in cycle NUM_NEURONS+PIPE_LAT+2.
REQ-024 start while busy or in DONE is ignored, with no queuing.
REQ-025 y_vec slots are not cleared at start; they hold previous values until overwritten, and the whole of y_vec is valid only at done.
REQ-026 Address arithmetic wraps modulo 2^AW.
REQ-027 With NUM_NEURONS=1, ISSUE lasts exactly one cycle.
REQ-028 w_rd=0 outside ISSUE; w_addr holds its last value.

Reset
REQ-029 rst=1 at any edge, including mid-job, forces IDLE and clears busy, done, w_rd, the tag pipeline, and the counters. y_vec, n_x, n_w and n_bias clear to 0.
REQ-030 A job aborted by reset produces no done pulse; in-flight n_y values are discarded.

Configuration
REQ-031 Macro LAYER_SCHED_STATS_EN, when defined, adds output cyc_cnt (16 bits): cycles from start acceptance to done for the last job, loaded at done, saturating at 0xFFFF, reset to 0.
REQ-032 With LAYER_SCHED_STATS_EN undefined, the cyc_cnt port and its logic are absent; all other behaviour is identical.

Structure
REQ-033 A shared package nn_pkg holds: the state enum, the constants NEURON_IN=7 and DW=17, and the packed-word field offsets for w_data.
REQ-034 One sub-module, issue_tag_pipe: parameterised depth shift register of {valid, index}, with synchronous clear.
REQ-035 Arithmetic itself stays in the neuron datapath; this block contains no multipliers.

Verification
REQ-036 Defaults, layer_base=0x10, memory model word k holds bias=k: start -> w_addr 0x10..0x16 on cycles 1..7; done at cycle 15; y_vec slot k equals a stub neuron output of k+1.
REQ-037 start pulsed again at cycles 3 and 15 (DONE cycle) -> both ignored; a single done; busy continuous from cycle 1 to 14.
REQ-038 rst asserted at cycle 5 of a job -> IDLE next cycle, busy=0, w_rd=0, no done; a fresh start completes normally in 15 cycles.
REQ-039 layer_base=0xFE, NUM_NEURONS=4, AW=8 -> addresses 0xFE, 0xFF, 0x00, 0x01.
REQ-040 NUM_NEURONS=1, PIPE_LAT=1 -> single w_rd at cycle 1; capture at cycle 3; done at cycle 4.
REQ-041 LAYER_SCHED_STATS_EN defined, default parameters -> cyc_cnt=15 after done; build without the macro has no cyc_cnt port.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and constants for the layer scheduler and its neuron datapath interface.
package nn_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  localparam int unsigned NEURON_IN = 7;
  localparam int unsigned DW        = 17;
  localparam int unsigned XW        = NEURON_IN * DW;
  localparam int unsigned WORD_W    = XW + DW;

  // Weight-memory word layout: {weights, bias}
  localparam int unsigned BIAS_LSB  = 0;
  localparam int unsigned BIAS_MSB  = DW - 1;
  localparam int unsigned WGT_LSB   = DW;
  localparam int unsigned WGT_MSB   = WORD_W - 1;

endpackage

// File: rtl/issue_tag_pipe.sv
// Shift register of {valid, index} tags following each weight read through the
// memory and neuron latency; synchronous clear.
module issue_tag_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned IW    = 3
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          in_valid_i,
  input  logic [IW-1:0] in_idx_i,
  output logic          out_valid_o,
  output logic [IW-1:0] out_idx_o,
  output logic          head_valid_o,
  output logic          inner_busy_o
);

  logic [DEPTH-1:0]         valid_q;
  logic [DEPTH-1:0][IW-1:0] idx_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= {valid_q[DEPTH-2:0], in_valid_i};
      idx_q   <= {idx_q[DEPTH-2:0], in_idx_i};
    end
  end

  assign out_valid_o  = valid_q[DEPTH-1];
  assign out_idx_o    = idx_q[DEPTH-1];
  // Stage 0 is the cycle the memory word is on w_data.
  assign head_valid_o = valid_q[0];
  // Tags still in flight other than the one leaving this cycle.
  assign inner_busy_o = |valid_q[DEPTH-2:0];

endmodule

// File: rtl/layer_scheduler.sv
// Sequences one layer of neurons through a shared neuron datapath.
// Optional LAYER_SCHED_STATS_EN adds a cyc_cnt output (cycles from start to done).
module layer_scheduler
  import nn_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 7,
  parameter int unsigned PIPE_LAT    = 6,
  parameter int unsigned AW          = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [AW-1:0]             layer_base,
  input  logic [XW-1:0]             x_in,
  output logic [AW-1:0]             w_addr,
  output logic                      w_rd,
  input  logic [WORD_W-1:0]         w_data,
  output logic [XW-1:0]             n_x,
  output logic [XW-1:0]             n_w,
  output logic [DW-1:0]             n_bias,
  input  logic [DW-1:0]             n_y,
  output logic [DW*NUM_NEURONS-1:0] y_vec,
  output logic                      busy,
  output logic                      done
`ifdef LAYER_SCHED_STATS_EN
  ,
  output logic [15:0]               cyc_cnt
`endif
);

  localparam int unsigned   IW       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int unsigned   TagDepth = 1 + PIPE_LAT;
  localparam logic [IW-1:0] LastIdx  = IW'(NUM_NEURONS - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] k_q, k_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [XW-1:0] x_q, x_d;
  logic [DW-1:0] y_q [NUM_NEURONS];
  logic [DW-1:0] y_d [NUM_NEURONS];
  logic          accept;
  logic          tag_out_valid, tag_head_valid, tag_inner_busy;
  logic [IW-1:0] tag_out_idx;

  assign accept = (state_q == StIdle) && start;

  issue_tag_pipe #(
    .DEPTH (TagDepth),
    .IW    (IW)
  ) u_tags (
    .clk_i        (clk),
    .clr_i        (rst),
    .in_valid_i   (w_rd),
    .in_idx_i     (k_q),
    .out_valid_o  (tag_out_valid),
    .out_idx_o    (tag_out_idx),
    .head_valid_o (tag_head_valid),
    .inner_busy_o (tag_inner_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: if (k_q == LastIdx) state_d = StDrain;
      StDrain: if (!tag_inner_busy) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    w_rd = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StIssue: begin
        w_rd = 1'b1;
        busy = 1'b1;
      end
      StDrain: busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    k_d    = k_q;
    addr_d = addr_q;
    x_d    = x_q;
    y_d    = y_q;
    if (accept) begin
      k_d    = '0;
      addr_d = layer_base;
      x_d    = x_in;
    end
    if (state_q == StIssue) begin
      k_d = k_q + 1'b1;
      // Stop on the last address so w_addr holds it after ISSUE.
      if (k_q != LastIdx) addr_d = addr_q + 1'b1;
    end
    for (int i = 0; i < int'(NUM_NEURONS); i++) begin
      if (tag_out_valid && tag_out_idx == IW'(i)) y_d[i] = n_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q    <= '0;
      addr_q <= '0;
      x_q    <= '0;
      for (int i = 0; i < int'(NUM_NEURONS); i++) y_q[i] <= '0;
    end else begin
      k_q    <= k_d;
      addr_q <= addr_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign w_addr = addr_q;
  assign n_x    = x_q;
  // Weights pass straight through while a read's data is on the bus, zero otherwise.
  assign n_w    = tag_head_valid ? w_data[WGT_MSB:WGT_LSB]   : '0;
  assign n_bias = tag_head_valid ? w_data[BIAS_MSB:BIAS_LSB] : '0;

  for (genvar g = 0; g < int'(NUM_NEURONS); g++) begin : g_yvec
    assign y_vec[g*DW +: DW] = y_q[g];
  end

`ifdef LAYER_SCHED_STATS_EN
  logic [15:0] run_q, cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
      cyc_q <= '0;
    end else begin
      if (accept) begin
        run_q <= 16'd1;
      end else if (state_q != StIdle && run_q != 16'hFFFF) begin
        run_q <= run_q + 16'd1;
      end
      if (done) cyc_q <= run_q;
    end
  end

  assign cyc_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler: default build, a wrapping 4-neuron build and a
// single-neuron build, each with a registered weight memory and a delayed stub neuron.
module tb_layer_scheduler;

  localparam logic [118:0] XA = {7{17'h0ABCD}};
  localparam logic [118:0] XB = {7{17'h13579}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [135:0] mem_word(input logic [7:0] addr, input logic [7:0] base);
    logic [16:0] p;
    p = {9'd0, addr} ^ 17'h1A5A5;
    return {{7{p}}, {9'd0, 8'(addr - base)}};
  endfunction

  // ---------------- DUT A: default parameters
  logic         a_start = 1'b0, a_wrd, a_busy, a_done;
  logic [7:0]   a_base = '0, a_waddr;
  logic [118:0] a_x = '0, a_nx, a_nw, a_y;
  logic [135:0] a_wdata = '0;
  logic [16:0]  a_nbias, a_ny;
  logic [16:0]  a_pl [6];
`ifdef LAYER_SCHED_STATS_EN
  logic [15:0]  a_cyc;
`endif

  layer_scheduler dut_a (
    .clk(clk), .rst(rst), .start(a_start), .layer_base(a_base), .x_in(a_x),
    .w_addr(a_waddr), .w_rd(a_wrd), .w_data(a_wdata), .n_x(a_nx), .n_w(a_nw),
    .n_bias(a_nbias), .n_y(a_ny), .y_vec(a_y), .busy(a_busy), .done(a_done)
`ifdef LAYER_SCHED_STATS_EN
    , .cyc_cnt(a_cyc)
`endif
  );

  always @(posedge clk) begin
    if (a_wrd) a_wdata <= mem_word(a_waddr, 8'h10);
    a_pl[0] <= a_nbias + 17'd1;
    for (int i = 1; i < 6; i++) a_pl[i] <= a_pl[i-1];
  end
  assign a_ny = a_pl[5];

  // ---------------- DUT B: 4 neurons, address wrap
  logic         b_start = 1'b0, b_wrd, b_busy, b_done;
  logic [7:0]   b_base = '0, b_waddr;
  logic [118:0] b_nx, b_nw;
  logic [67:0]  b_y;
  logic [135:0] b_wdata = '0;
  logic [16:0]  b_nbias, b_ny;
  logic [16:0]  b_pl [6];

  layer_scheduler #(.NUM_NEURONS(4), .PIPE_LAT(6), .AW(8)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .layer_base(b_base), .x_in(XA),
    .w_addr(b_waddr), .w_rd(b_wrd), .w_data(b_wdata), .n_x(b_nx), .n_w(b_nw),
    .n_bias(b_nbias), .n_y(b_ny), .y_vec(b_y), .busy(b_busy), .done(b_done)
`ifdef LAYER_SCHED_STATS_EN
    , .cyc_cnt()
`endif
  );

  always @(posedge clk) begin
    if (b_wrd) b_wdata <= mem_word(b_waddr, 8'hFE);
    b_pl[0] <= b_nbias + 17'd1;
    for (int i = 1; i < 6; i++) b_pl[i] <= b_pl[i-1];
  end
  assign b_ny = b_pl[5];

  // ---------------- DUT C: 1 neuron, PIPE_LAT 1
  logic         c_start = 1'b0, c_wrd, c_busy, c_done;
  logic [7:0]   c_base = '0, c_waddr;
  logic [118:0] c_nx, c_nw;
  logic [16:0]  c_y;
  logic [135:0] c_wdata = '0;
  logic [16:0]  c_nbias, c_ny, c_pl;

  layer_scheduler #(.NUM_NEURONS(1), .PIPE_LAT(1), .AW(8)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .layer_base(c_base), .x_in(XA),
    .w_addr(c_waddr), .w_rd(c_wrd), .w_data(c_wdata), .n_x(c_nx), .n_w(c_nw),
    .n_bias(c_nbias), .n_y(c_ny), .y_vec(c_y), .busy(c_busy), .done(c_done)
`ifdef LAYER_SCHED_STATS_EN
    , .cyc_cnt()
`endif
  );

  always @(posedge clk) begin
    if (c_wrd) c_wdata <= mem_word(c_waddr, 8'h10);
    c_pl <= c_nbias + 17'd1;
  end
  assign c_ny = c_pl;

  // ---------------- stimulus
  typedef struct {
    logic       start;
    logic       rd;
    logic [7:0] addr;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t        tbl [18];
  logic [7:0]  wrap_exp [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  task automatic job_a(input logic [7:0] base, output int dc);
    @(negedge clk);
    a_start = 1'b1;
    a_base  = base;
    dc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      a_start = 1'b0;
      if (a_done) begin
        dc = c;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          dc, nrd, rdc, pulses;
    logic [7:0]  seen [4];
    logic [135:0] wexp;

    // Main job, with extra starts at cycle 3 (ISSUE) and 15 (DONE) that must be ignored
    for (int c = 0; c < 18; c++) tbl[c] = '{start: 1'b0, rd: 1'b0, addr: 8'h16, busy: 1'b0, done: 1'b0};
    tbl[0].start = 1'b1;
    tbl[0].addr  = 8'h00;
    for (int c = 1; c <= 7; c++) begin
      tbl[c].rd   = 1'b1;
      tbl[c].addr = 8'h10 + 8'(c - 1);
      tbl[c].busy = 1'b1;
    end
    for (int c = 8; c <= 14; c++) tbl[c].busy = 1'b1;
    tbl[3].start  = 1'b1;
    tbl[15].start = 1'b1;
    tbl[15].done  = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", a_busy, 0);
    chk("rst_w_rd", a_wrd, 0);
    chk("rst_done", a_done, 0);
    chk("rst_y_vec", a_y, 0);
    chk("rst_n_x", a_nx, 0);
    chk("rst_n_w", a_nw, 0);

    a_base = 8'h10;
    a_x    = XA;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      a_start = tbl[c].start;
      if (c == 1) a_x = XB;
      chk($sformatf("c%0d_w_rd", c), a_wrd, tbl[c].rd);
      chk($sformatf("c%0d_w_addr", c), a_waddr, tbl[c].addr);
      chk($sformatf("c%0d_busy", c), a_busy, tbl[c].busy);
      chk($sformatf("c%0d_done", c), a_done, tbl[c].done);
      if (c >= 2 && c <= 8) begin
        wexp = mem_word(8'h10 + 8'(c - 2), 8'h10);
        chk($sformatf("c%0d_n_bias", c), a_nbias, c - 2);
        chk($sformatf("c%0d_n_w", c), a_nw, wexp[135:17]);
        chk($sformatf("c%0d_n_x", c), a_nx, XA);
      end
    end
    for (int k = 0; k < 7; k++) chk($sformatf("jobA_slot%0d", k), a_y[k*17 +: 17], k + 1);
`ifdef LAYER_SCHED_STATS_EN
    chk("jobA_cyc_cnt", a_cyc, 15);
`endif

    // Second job from base 0x20: slots keep old values until overwritten
    @(negedge clk);
    a_start = 1'b1;
    a_base  = 8'h20;
    dc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      a_start = 1'b0;
      if (c == 9) begin
        chk("jobB_c9_slot0_new", a_y[16:0], 17);
        chk("jobB_c9_slot6_old", a_y[118:102], 7);
      end
      if (a_done) begin
        dc = c;
        break;
      end
    end
    chk("jobB_done_cycle", dc, 15);
    for (int k = 0; k < 7; k++) chk($sformatf("jobB_slot%0d", k), a_y[k*17 +: 17], k + 17);

    // Reset in the middle of a job
    @(negedge clk);
    a_start = 1'b1;
    a_base  = 8'h10;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      a_start = 1'b0;
      if (c == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", a_busy, 0);
    chk("abort_w_rd", a_wrd, 0);
    chk("abort_done", a_done, 0);
    chk("abort_y_vec", a_y, 0);
    chk("abort_n_x", a_nx, 0);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    chk("abort_no_capture", a_y, 0);
    job_a(8'h10, dc);
    chk("fresh_done_cycle", dc, 15);
    for (int k = 0; k < 7; k++) chk($sformatf("fresh_slot%0d", k), a_y[k*17 +: 17], k + 1);

    // Address wrap, 4 neurons from 0xFE
    @(negedge clk);
    b_start = 1'b1;
    b_base  = 8'hFE;
    dc = -1;
    nrd = 0;
    rdc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      b_start = 1'b0;
      if (b_wrd) begin
        if (nrd == 0) rdc = c;
        if (nrd < 4) seen[nrd] = b_waddr;
        nrd++;
      end
      if (b_done) begin
        dc = c;
        break;
      end
    end
    chk("wrap_read_count", nrd, 4);
    chk("wrap_first_read_cycle", rdc, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_addr%0d", i), seen[i], wrap_exp[i]);
    chk("wrap_done_cycle", dc, 12);
    for (int k = 0; k < 4; k++) chk($sformatf("wrap_slot%0d", k), b_y[k*17 +: 17], k + 1);

    // Single neuron, PIPE_LAT 1
    @(negedge clk);
    c_start = 1'b1;
    c_base  = 8'h10;
    dc = -1;
    nrd = 0;
    rdc = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      c_start = 1'b0;
      if (c_wrd) begin
        nrd++;
        rdc = c;
      end
      if (c == 3) chk("n1_c3_slot_old", c_y, 0);
      if (c == 4) chk("n1_c4_slot_new", c_y, 1);
      if (c_done && dc < 0) dc = c;
    end
    chk("n1_read_count", nrd, 1);
    chk("n1_read_cycle", rdc, 1);
    chk("n1_done_cycle", dc, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
